adc_framer: RTL and testbench
=============================

ADC_FRAMER -- requirements
Module: adc_framer

Interface
REQ-001 Parameter NUM_CHANNELS, default 2, number of I/Q ADC channels (legal 1..8).
REQ-002 Parameter WIDTH, default 16, bits per I or Q component.
REQ-003 Parameter DEPTH, default 16, output FIFO entries (power of 2, >=2).
REQ-004 Derived CHAN_BITS = max(1, clog2(NUM_CHANNELS)).
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  capture enable.
REQ-008 chan_mask  in  NUM_CHANNELS  per-channel enable; bit k selects channel k.
REQ-009 frame_len  in  16  sample sets per frame; 0 treated as 1.
REQ-010 adc_valid  in  1  all channels' samples valid this cycle.
REQ-011 adc_data  in  NUM_CHANNELS*2*WIDTH  channel k at [2*WIDTH*k +: 2*WIDTH], {Q,I}, I in low half.
REQ-012 m_valid  out  1  stream valid.
REQ-013 m_ready  in  1  stream ready.
REQ-014 m_data  out  2*WIDTH  {Q,I} sample.
REQ-015 m_user  out  CHAN_BITS  channel index of m_data.
REQ-016 m_last  out  1  final entry of frame.
REQ-017 overflow  out  1  sticky: a sample set was dropped.
REQ-018 irq  out  1  one-cycle frame-complete pulse.

Function
REQ-019 Capture: adc_valid & enable & |chan_mask & serializer IDLE -> all channels registered into staging bank; serializer -> SHIFT.
REQ-020 chan_mask and frame_len latched at capture of first set of a frame (frame counter 0); mid-frame changes ignored until next frame.
REQ-021 SHIFT: one FIFO write per cycle, enabled channels in ascending index, entry = {last, chan, data}; after highest enabled channel -> IDLE.
REQ-022 SHIFT stalls (no write, no advance) while FIFO full.
REQ-023 adc_valid & enable while serializer in SHIFT -> whole set dropped, overflow set, frame counter unchanged.
REQ-024 Capture at edge N with FIFO empty and m_ready high: first entry m_valid at cycle N+2; subsequent entries back-to-back.
REQ-025 Frame counter increments per captured set; last flag set on highest enabled channel of set number frame_len; counter then wraps to 0.
REQ-026 m_valid/m_data/m_user/m_last held stable while m_valid & !m_ready; entry popped only on m_valid & m_ready.
REQ-027 FIFO write and pop in same cycle when full or empty both honoured; occupancy never exceeds DEPTH nor underflows.
REQ-028 irq high exactly one cycle, the cycle after m_valid & m_ready & m_last.
REQ-029 enable deasserted: new captures ignored, set in SHIFT completes, frame counter cleared at next IDLE; FIFO continues draining.
REQ-030 chan_mask all zero at capture time: adc_valid ignored, no overflow.
REQ-031 overflow cleared only by reset.

Reset
REQ-032 reset: serializer IDLE, frame counter 0, FIFO empty, m_valid 0, m_data 0, m_user 0, m_last 0, overflow 0, irq 0; reset mid-frame discards all buffered entries.

Configuration
REQ-033 Macro ADC_FRAMER_DROP_COUNT_EN defined: extra output drop_count (16, out) counts dropped sets, saturates at 16'hFFFF, reset 0.
REQ-034 Macro undefined: no drop_count port, no counter logic; all other behaviour identical.

Verification
REQ-035 NUM_CHANNELS=2, mask=2'b11, frame_len=2, adc_valid every 4 cycles, m_ready=1 -> m_user 0,1,0,1; m_last on 4th entry only; irq one cycle after it.
REQ-036 mask=2'b10, adc_data ch1={16'h1234,16'h5678} -> single entry m_data=32'h12345678, m_user=1, m_valid at N+2.
REQ-037 mask=2'b11, adc_valid two consecutive cycles -> second set dropped, overflow=1, drop_count=1 (macro on).
REQ-038 DEPTH=4, m_ready=0, 3 sets mask=2'b11 -> 4 entries held, serializer stalls, data stable; m_ready=1 -> drains in order, no loss.
REQ-039 frame_len changed 3->1 mid-frame -> current frame ends after 3 sets; next frame m_last every set.
REQ-040 reset asserted with FIFO half full -> next cycle m_valid=0, overflow=0, irq=0; next capture starts new frame.

Source files
------------

// File: rtl/adc_framer.sv
// adc_framer: serializes multi-channel I/Q sets into a framed stream; ADC_FRAMER_DROP_COUNT_EN adds drop_count.
module adc_framer #(
  parameter int NUM_CHANNELS = 2,
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int CHAN_BITS = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_CHANNELS-1:0]         chan_mask,
  input  logic [15:0]                     frame_len,
  input  logic                            adc_valid,
  input  logic [NUM_CHANNELS*2*WIDTH-1:0] adc_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [2*WIDTH-1:0]              m_data,
  output logic [CHAN_BITS-1:0]            m_user,
  output logic                            m_last,
  output logic                            overflow,
  output logic                            irq
`ifdef ADC_FRAMER_DROP_COUNT_EN
  ,
  output logic [15:0]                     drop_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 1 + CHAN_BITS + 2 * WIDTH;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [NUM_CHANNELS*2*WIDTH-1:0] stage;
  logic [NUM_CHANNELS-1:0] mask_q, eff_mask;
  logic [15:0] len_q, eff_len, frame_cnt;
  logic last_set, first, capture, drop, pop, wr, has_next;
  logic [CHAN_BITS-1:0] cur, first_ch, next_ch;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wdata;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, avail;
  always_comb begin
    first = frame_cnt == 16'd0;
    eff_mask = first ? chan_mask : mask_q;
    eff_len = first ? (frame_len == 16'd0 ? 16'd1 : frame_len) : len_q;
    capture = state == IDLE && adc_valid && enable && |eff_mask;
    drop = state == SHIFT && adc_valid && enable;
    pop = m_valid && m_ready;
    wr = state == SHIFT && (count != (AW+1)'(DEPTH) || pop);
    avail = count - (AW+1)'(pop);
  end
  // lowest enabled channel overall, and lowest enabled channel above cur
  always_comb begin
    first_ch = '0;
    next_ch = '0;
    has_next = 1'b0;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      if (eff_mask[k]) first_ch = CHAN_BITS'(k);
      if (mask_q[k] && k > int'(cur)) begin
        next_ch = CHAN_BITS'(k);
        has_next = 1'b1;
      end
    end
    wdata = {last_set && !has_next, cur, stage[int'(cur)*2*WIDTH +: 2*WIDTH]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      stage <= '0;
      mask_q <= '0;
      len_q <= 16'd1;
      frame_cnt <= 16'd0;
      last_set <= 1'b0;
      cur <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (capture) begin
        stage <= adc_data;
        state <= SHIFT;
        cur <= first_ch;
        mask_q <= eff_mask;
        len_q <= eff_len;
        last_set <= frame_cnt + 16'd1 == eff_len;
        frame_cnt <= frame_cnt + 16'd1 == eff_len ? 16'd0 : frame_cnt + 16'd1;
      end else if (state == IDLE && !enable) begin
        frame_cnt <= 16'd0;
      end else if (wr) begin
        cur <= next_ch;
        if (!has_next) state <= IDLE;
      end
    end
  end
  always_ff @(posedge clk) if (wr) mem[wr_ptr] <= wdata;
  // outputs only expose entries written before this edge, giving the N+2 first-beat latency
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_user <= '0;
      m_last <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
      m_valid <= avail != '0;
      {m_last, m_user, m_data} <= mem[rd_ptr + AW'(pop)];
      irq <= pop && m_last;
    end
  end
`ifdef ADC_FRAMER_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) drop_count <= 16'd0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_adc_framer.sv
// tb_adc_framer: directed self-checking bench for adc_framer (2 channels, 16-bit, 4-entry FIFO).
module tb_adc_framer;
  logic clk = 1'b0;
  logic reset, enable, adc_valid, m_ready;
  logic [1:0] chan_mask;
  logic [15:0] frame_len;
  logic [63:0] adc_data;
  logic m_valid, m_last, overflow, irq;
  logic [31:0] m_data;
  logic [0:0] m_user;
`ifdef ADC_FRAMER_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  adc_framer #(.NUM_CHANNELS(2), .WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask), .frame_len(frame_len),
    .adc_valid(adc_valid), .adc_data(adc_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_user(m_user), .m_last(m_last), .overflow(overflow), .irq(irq)
`ifdef ADC_FRAMER_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );
  function automatic logic [31:0] dv(int s, int k);
    return 32'hA5000000 | 32'(s << 8) | 32'(k);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse();
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask
  task automatic setd(int s);
    adc_data = {dv(s, 1), dv(s, 0)};
  endtask
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic beat(string tag, int s, int k, logic last);
    logic [63:0] exp;
    exp = {29'd0, last, k[0], dv(s, k)};
    chk({tag, "_valid"}, {63'd0, m_valid}, 64'd1);
    chk(tag, {30'd0, m_last, m_user, m_data}, exp);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1'b1; enable = 1'b0; chan_mask = '0; frame_len = '0;
    adc_valid = 1'b0; adc_data = '0; m_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", m_valid, 0); chk("rst_data", m_data, 0); chk("rst_user", m_user, 0);
    chk("rst_last", m_last, 0); chk("rst_ovf", overflow, 0); chk("rst_irq", irq, 0);
    reset = 1'b0;
    // single channel 1, latency N+2
    enable = 1'b1; m_ready = 1'b1; chan_mask = 2'b10; frame_len = 16'd1;
    adc_data = {32'h12345678, 32'hAAAABBBB};
    pulse();
    chk("a_n0_valid", m_valid, 0);
    tick(); chk("a_n1_valid", m_valid, 0);
    tick(); chk("a_n2_valid", m_valid, 1); chk("a_data", m_data, 64'h12345678);
    chk("a_user", m_user, 1); chk("a_last", m_last, 1);
    tick(); chk("a_n3_valid", m_valid, 0); chk("a_irq", irq, 1);
    tick(); chk("a_irq_off", irq, 0);
    // two channels, frame_len 2, a set every 4 cycles
    chan_mask = 2'b11; frame_len = 16'd2; setd(1);
    pulse(); tick(); tick(); beat("b1c0", 1, 0, 1'b0);
    setd(2);
    tick(); beat("b1c1", 1, 1, 1'b0);
    pulse(); chk("b_gap_valid", m_valid, 0); chk("b_gap_irq", irq, 0);
    tick(); tick(); beat("b2c0", 2, 0, 1'b0);
    tick(); beat("b2c1", 2, 1, 1'b1);
    tick(); chk("b_irq", irq, 1); chk("b_end_valid", m_valid, 0);
    tick(); chk("b_irq_off", irq, 0);
    // consecutive adc_valid drops the second set
    frame_len = 16'd4; setd(3);
    adc_valid = 1'b1; tick(); tick(); adc_valid = 1'b0;
    chk("c_ovf", overflow, 1);
`ifdef ADC_FRAMER_DROP_COUNT_EN
    chk("c_drops", drop_count, 1);
`endif
    tick(); beat("c3c0", 3, 0, 1'b0);
    tick(); beat("c3c1", 3, 1, 1'b0);
    tick(); chk("c_ovf_sticky", overflow, 1); chk("c_no_extra", m_valid, 0);
    // disabled capture is ignored and clears the frame counter
    enable = 1'b0; pulse(); tick(); tick(); tick();
    chk("en_off_valid", m_valid, 0);
    enable = 1'b1;
    // reset with FIFO half full
    m_ready = 1'b0; frame_len = 16'd3; setd(4);
    pulse(); tick(); tick(); tick();
    chk("e_pre_valid", m_valid, 1);
    reset = 1'b1; tick();
    chk("e_valid", m_valid, 0); chk("e_ovf", overflow, 0); chk("e_irq", irq, 0);
`ifdef ADC_FRAMER_DROP_COUNT_EN
    chk("e_drops", drop_count, 0);
`endif
    reset = 1'b0;
    frame_len = 16'd1; chan_mask = 2'b01; m_ready = 1'b1; setd(5);
    pulse(); tick(); tick(); beat("e5c0", 5, 0, 1'b1);
    tick(); chk("e_no_stale", m_valid, 0); chk("e_irq_new", irq, 1);
    // all-zero mask ignores adc_valid
    chan_mask = 2'b00; pulse(); tick(); tick();
    chk("z_valid", m_valid, 0); chk("z_ovf", overflow, 0);
    // back-pressure: three sets into four entries
    m_ready = 1'b0; chan_mask = 2'b11; frame_len = 16'd1;
    setd(6); pulse(); tick(); tick(); tick();
    setd(7); pulse(); tick(); tick(); tick();
    setd(8); pulse(); tick(); tick(); tick(); tick();
    chk("d_ovf", overflow, 0);
    beat("d_hold", 6, 0, 1'b0);
    tick(); tick(); beat("d_hold2", 6, 0, 1'b0);
    m_ready = 1'b1;
    tick(); beat("d6c1", 6, 1, 1'b1);
    tick(); beat("d7c0", 7, 0, 1'b0);
    tick(); beat("d7c1", 7, 1, 1'b1);
    tick(); beat("d8c0", 8, 0, 1'b0);
    tick(); beat("d8c1", 8, 1, 1'b1);
    tick(); chk("d_drained", m_valid, 0); chk("d_ovf_end", overflow, 0);
    // frame_len 3 -> 1 mid-frame
    frame_len = 16'd3;
    for (int i = 1; i <= 4; i++) begin
      setd(10 + i);
      pulse();
      if (i == 1) frame_len = 16'd1;
      if (i > 1) chk("f_irq", irq, (i == 4) ? 1 : 0);
      tick(); tick(); beat("f_c0", 10 + i, 0, 1'b0);
      tick(); beat("f_c1", 10 + i, 1, i >= 3);
    end
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
